ram_stream_reader: RTL and testbench

Read-side client for a `ram_bank`. It streams a block of consecutive words out of the bank onto a valid/ready output port. On `start` it issues reads from `base_addr` for `len` words, wrapping at `MEM_HEIGHT`. It absorbs the bank's one-cycle registered-read latency and downstream back-pressure without losing or duplicating words. It sits between a `ram_bank` read port and any consumer of a word stream.

---
 rtl/ram_pkg.sv | 27 ++
 rtl/ram_rd_skid.sv | 54 +++++
 rtl/ram_stream_reader.sv | 124 ++++++++++++
 tb/tb_ram_stream_reader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for ram_bank clients: default geometry, FSM state
// encoding and the address-wrap helper used by reader and writer blocks.
package ram_pkg;

   localparam int ADDR_BIT_DEF   = 3;
   localparam int DATA_BIT_DEF   = 16;
   localparam int MEM_HEIGHT_DEF = 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

   // base + offset folded back into 0..height-1 with a compare and a
   // subtract, so depths that are not a power of two wrap correctly.
   // Callers keep base < height and offset < height.
   function automatic int unsigned wrap_addr(input int unsigned base,
                                             input int unsigned offset,
                                             input int unsigned height);
      int unsigned sum;
      sum = base + offset;
      if (sum >= height) begin
         sum = sum - height;
      end
      return sum;
   endfunction

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry FIFO that holds {last, data} words returning from the bank
// until the downstream consumer takes them.
module ram_rd_skid #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic [1:0]   count,
   output logic [W-1:0] head
);

   logic [W-1:0] slot_reg [2];
   logic         rd_ptr_reg;
   logic         wr_ptr_reg;
   logic [1:0]   count_reg;
   logic         do_push;
   logic         do_pop;

   assign do_pop  = pop && (count_reg != 2'd0);
   assign do_push = push && ((count_reg != 2'd2) || do_pop);

   // Storage, pointers and occupancy; push and pop together leave the count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_reg[0] <= '0;
         slot_reg[1] <= '0;
         rd_ptr_reg  <= 1'b0;
         wr_ptr_reg  <= 1'b0;
         count_reg   <= 2'd0;
      end else begin
         if (do_push) begin
            slot_reg[wr_ptr_reg] <= din;
            wr_ptr_reg           <= ~wr_ptr_reg;
         end
         if (do_pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign full  = (count_reg == 2'd2);
   assign count = count_reg;
   assign head  = slot_reg[rd_ptr_reg];

endmodule

// File: rtl/ram_stream_reader.sv
// Streams len consecutive words (wrapping at MEM_HEIGHT) out of a ram_bank
// read port onto a valid/ready port, absorbing the bank's one-cycle read
// latency and downstream back-pressure.
module ram_stream_reader
   import ram_pkg::*;
#(
   parameter int ADDR_BIT   = ADDR_BIT_DEF,
   parameter int DATA_BIT   = DATA_BIT_DEF,
   parameter int MEM_HEIGHT = MEM_HEIGHT_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [ADDR_BIT-1:0] base_addr,
   input  logic [ADDR_BIT:0]   len,
   output logic                busy,
   output logic                done,
   output logic                ram_en,
   output logic                ram_re,
   output logic [ADDR_BIT-1:0] ram_addr_r,
   input  logic [DATA_BIT-1:0] ram_d_r,
   output logic                m_valid,
   output logic [DATA_BIT-1:0] m_data,
   output logic                m_last,
   input  logic                m_ready
);

   localparam logic [ADDR_BIT:0] HEIGHT_L = (ADDR_BIT+1)'(MEM_HEIGHT);
   localparam logic [ADDR_BIT:0] ONE_L    = (ADDR_BIT+1)'(1);

   logic [1:0]          state_reg;
   logic [ADDR_BIT-1:0] base_reg;
   logic [ADDR_BIT:0]   len_reg;       // clamped word count of this transfer
   logic [ADDR_BIT:0]   issued_reg;    // reads sent to the bank
   logic [ADDR_BIT:0]   pushed_reg;    // words captured into the buffer
   logic                inflight_reg;  // a read was issued last cycle

   logic                push;
   logic                pop;
   logic                full;
   logic [1:0]          occ;
   logic [DATA_BIT:0]   head;
   logic                push_last;
   logic                room;
   logic                issue;
   logic [2:0]          credit;

   assign push      = inflight_reg;
   assign push_last = (pushed_reg == len_reg - ONE_L);
   assign pop       = m_valid && m_ready;

   // Words held plus the word on its way. A pop this cycle frees a slot for
   // the word that a read issued now will return, which is what sustains one
   // word per cycle while the consumer keeps up; occ + inflight never exceeds 2.
   assign credit = {1'b0, occ} + {2'b00, inflight_reg};
   assign room   = pop ? !(full && inflight_reg) : (credit < 3'd2);
   assign issue  = (state_reg == ST_RUN) && (issued_reg < len_reg) && room;

   assign ram_re     = issue;
   assign ram_en     = issue;
   assign ram_addr_r = issue ? ADDR_BIT'(wrap_addr(32'(base_reg), 32'(issued_reg),
                                                   32'(MEM_HEIGHT)))
                             : '0;

   assign busy    = (state_reg == ST_RUN);
   assign done    = (state_reg == ST_FINISH);
   assign m_valid = (occ != 2'd0);
   assign m_data  = m_valid ? head[DATA_BIT-1:0] : '0;
   assign m_last  = m_valid && head[DATA_BIT];

   ram_rd_skid #(
      .W(DATA_BIT + 1)
   ) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   ({push_last, ram_d_r}),
      .full  (full),
      .count (occ),
      .head  (head)
   );

   // Transfer FSM with address/word counters and the in-flight flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         base_reg     <= '0;
         len_reg      <= '0;
         issued_reg   <= '0;
         pushed_reg   <= '0;
         inflight_reg <= 1'b0;
      end else begin
         inflight_reg <= issue;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  base_reg   <= base_addr;
                  len_reg    <= (len > HEIGHT_L) ? HEIGHT_L : len;
                  issued_reg <= '0;
                  pushed_reg <= '0;
                  state_reg  <= (len == '0) ? ST_FINISH : ST_RUN;
               end
            end
            ST_RUN: begin
               if (issue) begin
                  issued_reg <= issued_reg + ONE_L;
               end
               if (push) begin
                  pushed_reg <= pushed_reg + ONE_L;
               end
               if (pop && m_last) begin
                  state_reg <= ST_FINISH;
               end
            end
            default: begin
               // FINISH lasts one cycle; start is not looked at here.
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader with a behavioural ram_bank
// (registered read) and a word-list reference model.
module tb_ram_stream_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  base_addr = '0;
   logic [3:0]  len = '0;
   logic        busy, done, ram_en, ram_re;
   logic [2:0]  ram_addr_r;
   logic [15:0] ram_d_r = '0;
   logic        m_valid, m_last;
   logic [15:0] m_data;
   logic        m_ready = 1'b0;

   logic [15:0] mem [8];
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ram_stream_reader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .ram_en     (ram_en),
      .ram_re     (ram_re),
      .ram_addr_r (ram_addr_r),
      .ram_d_r    (ram_d_r),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_last     (m_last),
      .m_ready    (m_ready)
   );

   // ram_bank model: registered read, output held until the next read
   always @(posedge clk) begin
      if (ram_en && ram_re) ram_d_r <= mem[ram_addr_r];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One transfer: build the expected word list, start, then check every cycle.
   task automatic run_xfer(input logic [2:0] b, input logic [3:0] l, input int mode, input bit inject);
      logic [15:0] exp_d[$];
      logic        exp_l[$];
      logic [2:0]  exp_a[$];
      int          n, beats, first_c, last_c;
      bit          seen_done, stalled;
      logic [15:0] held_d;
      logic        held_l;
      logic [5:0]  pat;
      pat = 6'b101001;   // ready per cycle: 1,0,0,1,0,1,...
      n = (int'(l) > 8) ? 8 : int'(l);
      for (int k = 0; k < n; k++) begin
         exp_a.push_back(3'((int'(b) + k) % 8));
         exp_d.push_back(mem[(int'(b) + k) % 8]);
         exp_l.push_back(k == n - 1);
      end
      $display("xfer base=%0d len=%0d mode=%0d inject=%0d expect %0d words", b, l, mode, inject, n);
      @(negedge clk);
      start = 1'b1; base_addr = b; len = l;
      @(posedge clk); #1;
      start = 1'b0;
      beats = 0; first_c = -1; last_c = -1; seen_done = 0; stalled = 0;
      held_d = '0; held_l = 1'b0;
      for (int c = 0; c < 100; c++) begin
         case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = pat[c % 6];
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         start = inject && (c == 3);
         if (start) begin
            base_addr = 3'($urandom);
            len = 4'($urandom_range(1, 15));
         end
         @(negedge clk);
         chk("ram_en", 32'(ram_en), 32'(ram_re));
         if (ram_re) begin
            if (exp_a.size() == 0) chk("extra_read", 32'(ram_re), 32'(0));
            else chk("rd_addr", 32'(ram_addr_r), 32'(exp_a.pop_front()));
         end
         if (m_valid && first_c < 0) begin
            first_c = c;
            chk("first_valid_lat", 32'(c), 32'(2));
         end
         if (stalled) begin
            chk("stall_valid", 32'(m_valid), 32'(1));
            chk("stall_data", 32'(m_data), 32'(held_d));
            chk("stall_last", 32'(m_last), 32'(held_l));
         end
         if (m_valid && m_ready) begin
            if (exp_d.size() == 0) chk("extra_beat", 32'(m_valid), 32'(0));
            else begin
               chk("beat_data", 32'(m_data), 32'(exp_d.pop_front()));
               chk("beat_last", 32'(m_last), 32'(exp_l.pop_front()));
               if (mode == 0) chk("beat_cycle", 32'(c), 32'(2 + beats));
            end
            beats++;
            last_c = c;
         end
         stalled = m_valid && !m_ready;
         held_d = m_data;
         held_l = m_last;
         if (done) begin
            seen_done = 1;
            chk("done_busy", 32'(busy), 32'(0));
            chk("done_cycle", 32'(c), 32'((n == 0) ? 0 : last_c + 1));
            chk("beat_count", 32'(beats), 32'(n));
            chk("reads_left", 32'(exp_a.size()), 32'(0));
            break;
         end
         chk("busy", 32'(busy), 32'(1));
         @(posedge clk); #1;
      end
      if (!seen_done) chk("done_timeout", 32'(done), 32'(1));
      if (inject && seen_done) begin
         // start during the FINISH cycle must be ignored
         start = 1'b1; base_addr = 3'd2; len = 4'd3;
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         chk("fin_start_busy", 32'(busy), 32'(0));
         chk("fin_start_done", 32'(done), 32'(0));
         chk("fin_start_re", 32'(ram_re), 32'(0));
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_re", 32'(ram_re), 32'(0));
      chk("rst_en", 32'(ram_en), 32'(0));
      chk("rst_addr", 32'(ram_addr_r), 32'(0));
      chk("rst_valid", 32'(m_valid), 32'(0));
      chk("rst_last", 32'(m_last), 32'(0));
      chk("rst_data", 32'(m_data), 32'(0));
      rst_n = 1'b1;

      run_xfer(3'd0, 4'd8, 0, 0);    // basic
      run_xfer(3'd6, 4'd4, 0, 0);    // wrap
      run_xfer(3'd2, 4'd5, 1, 0);    // back-pressure
      run_xfer(3'd3, 4'd0, 0, 0);    // zero length
      run_xfer(3'd3, 4'd1, 0, 0);    // single word
      run_xfer(3'd5, 4'd15, 0, 0);   // clamped to depth
      run_xfer(3'd1, 4'd8, 1, 1);    // starts during transfer and FINISH
      run_xfer(3'd4, 4'd2, 0, 0);    // next accepted start runs normally

      // randomized contents and transfers
      for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
      for (int t = 0; t < 25; t++) begin
         run_xfer(3'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 2), 0);
      end

      // reset with one word buffered and one read in flight
      @(negedge clk);
      start = 1'b1; base_addr = 3'd4; len = 4'd8; m_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(m_valid), 32'(0));
      chk("arst_data", 32'(m_data), 32'(0));
      chk("arst_last", 32'(m_last), 32'(0));
      chk("arst_busy", 32'(busy), 32'(0));
      chk("arst_re", 32'(ram_re), 32'(0));
      chk("arst_addr", 32'(ram_addr_r), 32'(0));
      repeat (3) begin
         @(negedge clk);
         chk("arst_no_done", 32'(done), 32'(0));
      end
      rst_n = 1'b1;
      run_xfer(3'($urandom), 4'd3, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
